// File: rtl/line_transfer_engine.sv
// Cache line transfer engine: optional dirty-victim writeback burst, then line fill into the data array.
// Define LTE_PERF_CNT_EN to add the wb_count / fill_count performance counters.
module line_transfer_engine #(
   parameter int unsigned LINE_SIZE     = 64,
   parameter int unsigned NUM_SETS      = 64,
   parameter int unsigned ASSOCIATIVITY = 4,
   parameter int unsigned MEM_WIDTH     = 64,
   parameter int unsigned ADDR_WIDTH    = 32
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic                             req_dirty,
   input  logic [$clog2(NUM_SETS)-1:0]      req_index,
   input  logic [$clog2(ASSOCIATIVITY)-1:0] req_way,
   input  logic [ADDR_WIDTH-1:0]            req_wb_addr,
   input  logic [ADDR_WIDTH-1:0]            req_fill_addr,
   output logic                             done,
`ifdef LTE_PERF_CNT_EN
   output logic [31:0]                      wb_count,
   output logic [31:0]                      fill_count,
`endif
   output logic                             da_line_read_en,
   output logic                             da_line_write_en,
   output logic [$clog2(NUM_SETS)-1:0]      da_index,
   output logic [$clog2(ASSOCIATIVITY)-1:0] da_way,
   output logic [LINE_SIZE*8-1:0]           da_line_write_data,
   input  logic [LINE_SIZE*8-1:0]           da_line_read_data,
   output logic                             mem_req_valid,
   input  logic                             mem_req_ready,
   output logic                             mem_req_write,
   output logic [ADDR_WIDTH-1:0]            mem_req_addr,
   output logic                             mem_wdata_valid,
   input  logic                             mem_wdata_ready,
   output logic [MEM_WIDTH-1:0]             mem_wdata,
   output logic                             mem_wlast,
   input  logic                             mem_rdata_valid,
   output logic                             mem_rdata_ready,
   input  logic [MEM_WIDTH-1:0]             mem_rdata
);

   localparam int unsigned BEATS = (LINE_SIZE * 8) / MEM_WIDTH;
   localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [3:0] {
      StIdle,
      StWbRd,
      StWbCap,
      StWbAreq,
      StWbData,
      StFillAreq,
      StFillData,
      StFillWr,
      StDone
   } state_e;

   state_e                           state;
   logic [CNT_W-1:0]                 beat;
   logic [BEATS-1:0][MEM_WIDTH-1:0]  line_buf;
   logic [ADDR_WIDTH-1:0]            wb_addr;
   logic [ADDR_WIDTH-1:0]            fill_addr;

   // One buffer serves both directions: victim line on the way out, fill line on the way in.
   assign da_line_write_data = line_buf;
   assign mem_wdata          = line_buf[beat];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= StIdle;
         req_ready        <= 1'b1;
         done             <= 1'b0;
         da_line_read_en  <= 1'b0;
         da_line_write_en <= 1'b0;
         da_index         <= '0;
         da_way           <= '0;
         mem_req_valid    <= 1'b0;
         mem_req_write    <= 1'b0;
         mem_req_addr     <= '0;
         mem_wdata_valid  <= 1'b0;
         mem_wlast        <= 1'b0;
         mem_rdata_ready  <= 1'b0;
         beat             <= '0;
         line_buf         <= '0;
         wb_addr          <= '0;
         fill_addr        <= '0;
`ifdef LTE_PERF_CNT_EN
         wb_count         <= '0;
         fill_count       <= '0;
`endif
      end else begin
         done             <= 1'b0;
         da_line_read_en  <= 1'b0;
         da_line_write_en <= 1'b0;
         unique case (state)
            StIdle: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  da_index  <= req_index;
                  da_way    <= req_way;
                  wb_addr   <= req_wb_addr;
                  fill_addr <= req_fill_addr;
                  beat      <= '0;
                  if (req_dirty) begin
                     state           <= StWbRd;
                     da_line_read_en <= 1'b1;
                  end else begin
                     state         <= StFillAreq;
                     mem_req_valid <= 1'b1;
                     mem_req_write <= 1'b0;
                     mem_req_addr  <= req_fill_addr;
                  end
               end
            end
            StWbRd: begin
               state <= StWbCap;
            end
            StWbCap: begin
               line_buf      <= da_line_read_data;
               state         <= StWbAreq;
               mem_req_valid <= 1'b1;
               mem_req_write <= 1'b1;
               mem_req_addr  <= wb_addr;
            end
            StWbAreq: begin
               if (mem_req_ready) begin
                  mem_req_valid   <= 1'b0;
                  state           <= StWbData;
                  beat            <= '0;
                  mem_wdata_valid <= 1'b1;
                  mem_wlast       <= (BEATS == 1);
               end
            end
            StWbData: begin
               if (mem_wdata_ready) begin
                  if (beat == LAST_BEAT) begin
                     mem_wdata_valid <= 1'b0;
                     mem_wlast       <= 1'b0;
                     beat            <= '0;
                     state           <= StFillAreq;
                     mem_req_valid   <= 1'b1;
                     mem_req_write   <= 1'b0;
                     mem_req_addr    <= fill_addr;
`ifdef LTE_PERF_CNT_EN
                     wb_count        <= wb_count + 32'd1;
`endif
                  end else begin
                     beat      <= beat + 1'b1;
                     mem_wlast <= (beat == LAST_BEAT - 1'b1);
                  end
               end
            end
            StFillAreq: begin
               if (mem_req_ready) begin
                  mem_req_valid   <= 1'b0;
                  state           <= StFillData;
                  beat            <= '0;
                  mem_rdata_ready <= 1'b1;
               end
            end
            StFillData: begin
               if (mem_rdata_valid) begin
                  line_buf[beat] <= mem_rdata;
                  if (beat == LAST_BEAT) begin
                     mem_rdata_ready  <= 1'b0;
                     beat             <= '0;
                     state            <= StFillWr;
                     da_line_write_en <= 1'b1;
                  end else begin
                     beat <= beat + 1'b1;
                  end
               end
            end
            StFillWr: begin
               state <= StDone;
               done  <= 1'b1;
`ifdef LTE_PERF_CNT_EN
               fill_count <= fill_count + 32'd1;
`endif
            end
            StDone: begin
               state     <= StIdle;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= StIdle;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_line_transfer_engine.sv
// Scoreboard bench for line_transfer_engine: random transfers against a line/beat level model,
// with a memory responder that can stall, toggle readiness and gap read beats.
module tb_line_transfer_engine;

   localparam int unsigned LINE_SIZE     = 64;
   localparam int unsigned NUM_SETS      = 64;
   localparam int unsigned ASSOCIATIVITY = 4;
   localparam int unsigned MEM_WIDTH     = 64;
   localparam int unsigned ADDR_WIDTH    = 32;
   localparam int unsigned LINE_W        = LINE_SIZE * 8;
   localparam int unsigned BEATS         = LINE_W / MEM_WIDTH;
   localparam int unsigned IDX_W         = $clog2(NUM_SETS);
   localparam int unsigned WAY_W         = $clog2(ASSOCIATIVITY);

   typedef logic [LINE_W-1:0] line_t;
   typedef struct packed { logic wr; logic [ADDR_WIDTH-1:0] addr; } req_t;
   typedef struct packed { logic [MEM_WIDTH-1:0] data; logic last; } wbeat_t;
   typedef struct packed { logic [IDX_W-1:0] idx; logic [WAY_W-1:0] way; line_t line; } lwr_t;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  req_valid, req_ready, req_dirty, done;
   logic [IDX_W-1:0]      req_index, da_index;
   logic [WAY_W-1:0]      req_way, da_way;
   logic [ADDR_WIDTH-1:0] req_wb_addr, req_fill_addr, mem_req_addr;
   logic                  da_line_read_en, da_line_write_en;
   line_t                 da_line_write_data, da_line_read_data;
   logic                  mem_req_valid, mem_req_ready, mem_req_write;
   logic                  mem_wdata_valid, mem_wdata_ready, mem_wlast;
   logic [MEM_WIDTH-1:0]  mem_wdata, mem_rdata;
   logic                  mem_rdata_valid, mem_rdata_ready;
`ifdef LTE_PERF_CNT_EN
   logic [31:0]           wb_count, fill_count;
`endif

   always #5 clk = ~clk;

   line_transfer_engine #(
      .LINE_SIZE(LINE_SIZE), .NUM_SETS(NUM_SETS), .ASSOCIATIVITY(ASSOCIATIVITY),
      .MEM_WIDTH(MEM_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_dirty(req_dirty),
      .req_index(req_index), .req_way(req_way),
      .req_wb_addr(req_wb_addr), .req_fill_addr(req_fill_addr),
      .done(done),
`ifdef LTE_PERF_CNT_EN
      .wb_count(wb_count), .fill_count(fill_count),
`endif
      .da_line_read_en(da_line_read_en), .da_line_write_en(da_line_write_en),
      .da_index(da_index), .da_way(da_way),
      .da_line_write_data(da_line_write_data), .da_line_read_data(da_line_read_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
      .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
      .mem_wdata(mem_wdata), .mem_wlast(mem_wlast),
      .mem_rdata_valid(mem_rdata_valid), .mem_rdata_ready(mem_rdata_ready),
      .mem_rdata(mem_rdata)
   );

   req_t   exp_req_q[$];
   wbeat_t exp_wbeat_q[$];
   lwr_t   exp_lwr_q[$];
   int     exp_lat_q[$];
   line_t  fill_q[$];
   line_t  cur_victim;
   int     fill_ptr = 0;
   int     mode = 0;
   int     vectors = 0, miscompares = 0;
   int     done_cnt = 0, lwr_cnt = 0, wbeat_cnt = 0, cycle = 0, accept_cycle = 0;

   task automatic check(input string name, input logic [LINE_W-1:0] act,
                        input logic [LINE_W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: got an unexpected event, expected none", name);
   endtask

   function automatic line_t rand_line();
      line_t l;
      for (int i = 0; i < int'(LINE_W / 32); i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] rand_addr();
      return ADDR_WIDTH'($urandom) & ~ADDR_WIDTH'(LINE_SIZE - 1);
   endfunction

   // Memory and data-array responder.
   initial begin : mem_side
      logic  rr_s, rd_s;
      int    req_wait;
      line_t cur;
      req_wait = 0;
      mem_req_ready = 1'b0; mem_wdata_ready = 1'b0; mem_rdata_valid = 1'b0;
      mem_rdata = '0; da_line_read_data = '0;
      forever begin
         @(negedge clk);
         rr_s = mem_rdata_ready;
         rd_s = da_line_read_en;
         if (mem_req_valid && !mem_req_ready) req_wait++;
         else req_wait = 0;
         @(posedge clk);
         if (rst_n && mem_rdata_valid && rr_s && fill_q.size() > 0) begin
            fill_ptr++;
            if (fill_ptr == int'(BEATS)) begin
               fill_ptr = 0;
               void'(fill_q.pop_front());
            end
         end
         #1;
         case (mode)
            0: begin
               mem_req_ready = 1'b1; mem_wdata_ready = 1'b1; mem_rdata_valid = 1'b1;
            end
            1: begin
               mem_req_ready   = (req_wait >= 3);
               mem_wdata_ready = ~mem_wdata_ready;
               mem_rdata_valid = ~mem_rdata_valid;
            end
            default: begin
               mem_req_ready   = ($urandom_range(0, 2) != 0);
               mem_wdata_ready = ($urandom_range(0, 2) != 0);
               mem_rdata_valid = ($urandom_range(0, 2) != 0);
            end
         endcase
         if (fill_q.size() > 0) begin
            cur = fill_q[0];
            mem_rdata = cur[fill_ptr*MEM_WIDTH +: MEM_WIDTH];
         end else begin
            mem_rdata = MEM_WIDTH'({$urandom, $urandom});
         end
         da_line_read_data = rd_s ? cur_victim : rand_line();
      end
   end

   // Monitor: pops expectations whenever the DUT presents an output.
   initial begin : monitor
      logic   req_pend, w_pend;
      req_t   prev_req, er;
      wbeat_t prev_w, ew;
      lwr_t   el;
      int     lat;
      req_pend = 1'b0; w_pend = 1'b0;
      forever begin
         @(negedge clk);
         cycle++;
         if (!rst_n) begin
            req_pend = 1'b0;
            w_pend   = 1'b0;
         end else begin
            if (req_valid && req_ready) accept_cycle = cycle;
            if (req_pend)
               check("req_hold", {mem_req_valid, mem_req_write, mem_req_addr},
                     {1'b1, prev_req.wr, prev_req.addr});
            if (mem_req_valid && mem_req_ready) begin
               if (exp_req_q.size() == 0) unexpected("mem_req");
               else begin
                  er = exp_req_q.pop_front();
                  check("mem_req", {mem_req_write, mem_req_addr}, {er.wr, er.addr});
               end
            end
            req_pend = mem_req_valid && !mem_req_ready;
            prev_req = '{wr: mem_req_write, addr: mem_req_addr};

            if (w_pend)
               check("wbeat_hold", {mem_wdata_valid, mem_wdata, mem_wlast},
                     {1'b1, prev_w.data, prev_w.last});
            if (mem_wdata_valid && mem_wdata_ready) begin
               wbeat_cnt++;
               if (exp_wbeat_q.size() == 0) unexpected("wbeat");
               else begin
                  ew = exp_wbeat_q.pop_front();
                  check("wbeat", {mem_wdata, mem_wlast}, {ew.data, ew.last});
               end
            end
            w_pend = mem_wdata_valid && !mem_wdata_ready;
            prev_w = '{data: mem_wdata, last: mem_wlast};

            if (da_line_read_en || da_line_write_en)
               check("strobe_excl", LINE_W'(da_line_read_en & da_line_write_en), '0);
            if (da_line_write_en) begin
               lwr_cnt++;
               if (exp_lwr_q.size() == 0) unexpected("line_write");
               else begin
                  el = exp_lwr_q.pop_front();
                  check("lwr_slot", {da_index, da_way}, {el.idx, el.way});
                  check("lwr_line", da_line_write_data, el.line);
               end
            end
            if (done) begin
               done_cnt++;
               if (exp_lat_q.size() == 0) unexpected("done");
               else begin
                  lat = exp_lat_q.pop_front();
                  if (lat >= 0) check("latency", LINE_W'(cycle - accept_cycle), LINE_W'(lat));
               end
            end
         end
      end
   end

   // Reference model: a transfer is the victim beats, two requests, one line write and a done.
   task automatic start(input logic [IDX_W-1:0] idx, input logic [WAY_W-1:0] way,
                        input logic dirty, input logic [ADDR_WIDTH-1:0] wb,
                        input logic [ADDR_WIDTH-1:0] fill, input line_t victim,
                        input line_t fill_line, input int lat);
      req_t   r;
      wbeat_t w;
      lwr_t   l;
      bit     acc;
      if (dirty) begin
         r = '{wr: 1'b1, addr: wb};
         exp_req_q.push_back(r);
         for (int k = 0; k < int'(BEATS); k++) begin
            w.data = victim[k*MEM_WIDTH +: MEM_WIDTH];
            w.last = (k == int'(BEATS) - 1);
            exp_wbeat_q.push_back(w);
         end
      end
      r = '{wr: 1'b0, addr: fill};
      exp_req_q.push_back(r);
      l = '{idx: idx, way: way, line: fill_line};
      exp_lwr_q.push_back(l);
      exp_lat_q.push_back(lat);
      fill_q.push_back(fill_line);
      cur_victim = victim;
      @(posedge clk); #1;
      req_valid = 1'b1; req_dirty = dirty; req_index = idx; req_way = way;
      req_wb_addr = wb; req_fill_addr = fill;
      acc = 0;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk);
         acc = req_ready;
      end
      if (!acc) unexpected("accept_timeout");
      @(posedge clk); #1;
      req_valid = 1'b0; req_dirty = 1'($urandom); req_index = IDX_W'($urandom);
      req_way = WAY_W'($urandom); req_wb_addr = ADDR_WIDTH'($urandom);
      req_fill_addr = ADDR_WIDTH'($urandom);
   endtask

   task automatic run(input logic [IDX_W-1:0] idx, input logic [WAY_W-1:0] way,
                      input logic dirty, input logic [ADDR_WIDTH-1:0] wb,
                      input logic [ADDR_WIDTH-1:0] fill, input line_t victim,
                      input line_t fill_line, input int lat);
      int n0;
      n0 = done_cnt;
      start(idx, way, dirty, wb, fill, victim, fill_line, lat);
      for (int i = 0; i < 2000 && done_cnt == n0; i++) @(negedge clk);
      if (done_cnt == n0) unexpected("done_timeout");
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_ctrl"}, {done, da_line_read_en, da_line_write_en, da_index, da_way,
            mem_req_valid, mem_req_write, mem_req_addr, mem_wdata_valid, mem_wlast,
            mem_rdata_ready}, '0);
      check({tag, "_wdata"}, mem_wdata, '0);
      check({tag, "_line"}, da_line_write_data, '0);
      check({tag, "_req_ready"}, LINE_W'(req_ready), LINE_W'(1));
`ifdef LTE_PERF_CNT_EN
      check({tag, "_counters"}, {wb_count, fill_count}, '0);
`endif
   endtask

   task automatic random_txn(input logic dirty);
      run(IDX_W'($urandom), WAY_W'($urandom), dirty, rand_addr(), rand_addr(),
          rand_line(), rand_line(), -1);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      line_t l0, l1;
      int    base, lwr0, done0;
      rst_n = 1'b0; req_valid = 1'b0; req_dirty = 1'b0; req_index = '0; req_way = '0;
      req_wb_addr = '0; req_fill_addr = '0; cur_victim = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state("init");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Clean miss, no stalls: beat k carries value k.
      mode = 0;
      for (int k = 0; k < int'(BEATS); k++) l0[k*MEM_WIDTH +: MEM_WIDTH] = MEM_WIDTH'(k);
      run(IDX_W'(5), WAY_W'(2), 1'b0, '0, 32'h0000_1040, rand_line(), l0, BEATS + 3);

      // Dirty miss, no stalls: victim byte b holds b.
      for (int b = 0; b < int'(LINE_SIZE); b++) l1[b*8 +: 8] = 8'(b);
      run(IDX_W'(9), WAY_W'(1), 1'b1, 32'h0000_2000, 32'h0000_3000, l1, rand_line(),
          2 * BEATS + 6);

      // Address stalls, toggling write ready, gapped read beats.
      mode = 1;
      random_txn(1'b1);
      random_txn(1'b0);

      mode = 2;
      for (int i = 0; i < 16; i++) random_txn(1'($urandom));
      check("sb_drain", LINE_W'(exp_req_q.size() + exp_wbeat_q.size() + exp_lwr_q.size() +
            exp_lat_q.size()), '0);

      // Reset while beat 3 of a writeback is on the bus.
      mode = 0;
      base = wbeat_cnt;
      start(IDX_W'($urandom), WAY_W'($urandom), 1'b1, rand_addr(), rand_addr(),
            rand_line(), rand_line(), -1);
      for (int i = 0; i < 100 && wbeat_cnt < base + 3; i++) begin
         @(posedge clk); #1;
      end
      check("rst_at_beat3", LINE_W'(wbeat_cnt - base), LINE_W'(3));
      rst_n = 1'b0;
      lwr0 = lwr_cnt;
      done0 = done_cnt;
      @(posedge clk);
      @(negedge clk);
      check_reset_state("midrst");
      exp_req_q.delete(); exp_wbeat_q.delete(); exp_lwr_q.delete(); exp_lat_q.delete();
      fill_q.delete();
      fill_ptr = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("no_lwr_after_rst", LINE_W'(lwr_cnt - lwr0), '0);
      check("no_done_after_rst", LINE_W'(done_cnt - done0), '0);

      // Two dirty misses and one clean miss after the reset.
      mode = 2;
      random_txn(1'b1);
      random_txn(1'b1);
      random_txn(1'b0);
`ifdef LTE_PERF_CNT_EN
      @(negedge clk);
      check("wb_count", LINE_W'(wb_count), LINE_W'(2));
      check("fill_count", LINE_W'(fill_count), LINE_W'(3));
`endif
      check("sb_drain_end", LINE_W'(exp_req_q.size() + exp_wbeat_q.size() +
            exp_lwr_q.size() + exp_lat_q.size()), '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
